// File: rtl/memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder_pkg
// Description : Shared ISA/architecture constants and types for the
//               fixed-latency memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_responder_pkg;

   // Machine word width in bits.
   localparam int unsigned XLEN             = 32;

   // Cycles from address sample to read data.
   // The fetch and load stages are built around this value.
   localparam int unsigned MEM_READ_LATENCY = 2;

   // One enable bit per byte lane; 4'b0000 means a read only.
   typedef logic [3:0] mem_strobe_t;

   // One slot of the read-response pipeline.
   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            valid;
      logic            fault;
   } mem_slot_t;

endpackage
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
// Module      : memory_array
// Description : DEPTH_WORDS x 32 single-port RAM.
//               Byte-enable write and registered (read-before-write) read.
//               Storage has no reset, so the array maps onto block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clock,
   input  logic [IDX_W-1:0] i_index,
   input  logic [31:0]      i_w_data,
   input  logic [3:0]       i_we,
   output logic [31:0]      o_r_data
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rd_data;

   // Byte-lane writes plus a registered read.
   // Non-blocking updates return the old word on a same-word write.
   always_ff @(posedge clock) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b]) begin
            r_mem[i_index][8*b +: 8] <= i_w_data[8*b +: 8];
         end
      end
      r_rd_data <= r_mem[i_index];
   end

   assign o_r_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Responder end of the core's fixed-latency memory port.
//               Word-addressed RAM; data returns READ_LATENCY cycles after the
//               address, with byte-strobed stores and range/alignment faults.
//               Optional macro MEM_MISALIGN_CHECK_EN turns a misaligned access
//               into a fault.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = MEM_READ_LATENCY   // legal 1..3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_w_data,
   input  mem_strobe_t     mem_w_strobe,
   output logic [XLEN-1:0] mem_r_data,
   output logic            mem_r_valid,
   output logic            mem_fault
);

   localparam int unsigned c_IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [XLEN:0] c_BYTE_LIMIT = (XLEN+1)'(4 * DEPTH_WORDS);

   logic        w_in_range;
   logic        w_align_ok;
   logic        w_ok;
   mem_strobe_t w_we;
   logic [31:0] w_ram_data;
   logic        r_s1_valid;
   logic        r_s1_fault;
   mem_slot_t   w_slot [READ_LATENCY];

   // Compare with one extra bit so that addresses near 2**XLEN cannot wrap.
   assign w_in_range = ({1'b0, mem_addr} < c_BYTE_LIMIT);

`ifdef MEM_MISALIGN_CHECK_EN
   // Accept only naturally aligned byte, half-word and word accesses.
   always_comb begin
      w_align_ok = 1'b0;
      if (mem_w_strobe == 4'b0000) begin
         w_align_ok = (mem_addr[1:0] == 2'b00);
      end else if (mem_w_strobe == (4'b0001 << mem_addr[1:0])) begin
         w_align_ok = 1'b1;
      end else if (!mem_addr[0] && (mem_w_strobe == (4'b0011 << mem_addr[1:0]))) begin
         w_align_ok = 1'b1;
      end else if ((mem_addr[1:0] == 2'b00) && (mem_w_strobe == 4'b1111)) begin
         w_align_ok = 1'b1;
      end
   end
`else
   assign w_align_ok = 1'b1;
`endif

   assign w_ok = w_in_range & w_align_ok;

   // Drop the store when reset is high or the access faults.
   assign w_we = (!reset && w_ok) ? mem_w_strobe : 4'b0000;

   memory_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (c_IDX_W)
   ) u_array (
      .clock    (clock),
      .i_index  (mem_addr[2 +: c_IDX_W]),
      .i_w_data (mem_w_data),
      .i_we     (w_we),
      .o_r_data (w_ram_data)
   );

   // Stage 1 status runs alongside the RAM's registered read.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_fault <= 1'b0;
      end else begin
         r_s1_valid <= w_ok;
         r_s1_fault <= ~w_ok;
      end
   end

   // Data is forced to zero on any slot that is not valid.
   // This covers reset and faulting samples.
   assign w_slot[0] = '{data:  (r_s1_valid ? w_ram_data : '0),
                        valid: r_s1_valid,
                        fault: r_s1_fault};

   for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
      mem_slot_t r_slot;

      // Plain delay stage; reset flushes whatever is in flight.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_slot <= '0;
         end else begin
            r_slot <= w_slot[k-1];
         end
      end

      assign w_slot[k] = r_slot;
   end

   assign mem_r_data  = w_slot[READ_LATENCY-1].data;
   assign mem_r_valid = w_slot[READ_LATENCY-1].valid;
   assign mem_fault   = w_slot[READ_LATENCY-1].fault;

endmodule
`default_nettype wire
